pll_reset_sequencer: RTL and testbench

//  Supervises the core PLL (73.728 / 36.864 / 3.579 MHz outputs) from the free-running 50 MHz ref clock.

---
 rtl/pll_reset_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// pll_reset_sequencer: PLL reset pulse, lock qualification, ordered domain reset release
// Revision 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int PLL_RST_CYC     = 32,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int RELOCK_TIMEOUT  = 65536,
  parameter int NUM_STAGES      = 3,
  parameter int STAGE_GAP       = 16
) (
  input  logic                  i_clk_sys,
  input  logic                  i_reset_n,
  input  logic                  i_pll_locked,
  input  logic                  i_force_reset,
  output logic                  o_pll_rst,
  output logic [NUM_STAGES-1:0] o_stage_rst,
  output logic                  o_ready,
  output logic [7:0]            o_relock_count
);

  localparam int c_MAX_SHORT = (PLL_RST_CYC > STAGE_GAP) ? PLL_RST_CYC : STAGE_GAP;
  localparam int c_MAX_LONG  = (RELOCK_TIMEOUT > LOCK_STABLE_CYC) ? RELOCK_TIMEOUT : LOCK_STABLE_CYC;
  localparam int c_CNT_MAX   = (c_MAX_LONG > c_MAX_SHORT) ? c_MAX_LONG : c_MAX_SHORT;
  localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
  localparam int c_IDX_W     = $clog2(NUM_STAGES + 1);

  localparam logic [c_CNT_W-1:0]    c_PLL_RST_LAST = c_CNT_W'(PLL_RST_CYC - 1);
  localparam logic [c_CNT_W-1:0]    c_TIMEOUT_LAST = c_CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]    c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [c_CNT_W-1:0]    c_GAP_LAST     = c_CNT_W'(STAGE_GAP - 1);
  localparam logic [c_IDX_W-1:0]    c_IDX_LAST     = c_IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] c_ALL_RST      = {NUM_STAGES{1'b1}};

  typedef enum logic [2:0] {
    ST_PLLRST   = 3'd0,
    ST_WAITLOCK = 3'd1,
    ST_STABLE   = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic [c_CNT_W-1:0]    w_cnt_inc;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [c_IDX_W-1:0]    w_idx_inc;
  logic                  r_pll_rst;
  logic                  w_pll_rst_nxt;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic [NUM_STAGES-1:0] w_stage_rst_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic [7:0]            r_relock;
  logic [7:0]            w_relock_nxt;
  logic                  r_lk_meta;
  logic                  r_lk;
  logic                  w_rel_step;
  logic                  w_drop;
  logic                  w_hold;

  // Lock input comes from the PLL's own domain; two flops before any use.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lk_meta <= 1'b0;
      r_lk      <= 1'b0;
    end else begin
      r_lk_meta <= i_pll_locked;
      r_lk      <= r_lk_meta;
    end
  end

  assign w_cnt_inc = r_cnt + c_CNT_W'(1);
  assign w_idx_inc = r_idx + c_IDX_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_pll_rst_nxt   = 1'b0;
    w_stage_rst_nxt = r_stage_rst;
    w_ready_nxt     = 1'b0;
    w_relock_nxt    = r_relock;
    w_rel_step      = 1'b0;
    w_drop          = 1'b0;
    w_hold          = 1'b0;

    case (r_state)
      ST_PLLRST: begin
        w_stage_rst_nxt = c_ALL_RST;
        if (r_cnt == c_PLL_RST_LAST) begin
          w_state_nxt = ST_WAITLOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_pll_rst_nxt = 1'b1;
          w_cnt_nxt     = w_cnt_inc;
        end
      end
      ST_WAITLOCK: begin
        w_stage_rst_nxt = c_ALL_RST;
        if (r_lk) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state_nxt   = ST_PLLRST;
          w_cnt_nxt     = '0;
          w_pll_rst_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_STABLE: begin
        w_stage_rst_nxt = c_ALL_RST;
        if (!r_lk) begin
          w_state_nxt = ST_WAITLOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_STABLE_LAST) begin
          w_rel_step = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RELEASE: begin
        // Index 0 here means a force request just cleared: release bit 0 at once.
        if (!r_lk) begin
          w_drop = 1'b1;
        end else if (i_force_reset) begin
          w_hold = 1'b1;
        end else if ((r_idx == '0) || (r_cnt == c_GAP_LAST)) begin
          w_rel_step = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RUN: begin
        w_stage_rst_nxt = '0;
        w_ready_nxt     = 1'b1;
        if (!r_lk) begin
          w_drop = 1'b1;
          if (r_relock != 8'hFF) begin
            w_relock_nxt = r_relock + 8'd1;
          end
        end else if (i_force_reset) begin
          w_hold = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_PLLRST;
        w_cnt_nxt       = '0;
        w_idx_nxt       = '0;
        w_pll_rst_nxt   = 1'b1;
        w_stage_rst_nxt = c_ALL_RST;
      end
    endcase

    if (w_drop) begin
      w_state_nxt     = ST_WAITLOCK;
      w_cnt_nxt       = '0;
      w_idx_nxt       = '0;
      w_stage_rst_nxt = c_ALL_RST;
      w_ready_nxt     = 1'b0;
    end

    if (w_hold) begin
      w_state_nxt     = ST_RELEASE;
      w_cnt_nxt       = '0;
      w_idx_nxt       = '0;
      w_stage_rst_nxt = c_ALL_RST;
      w_ready_nxt     = 1'b0;
    end

    if (w_rel_step) begin
      w_idx_nxt       = w_idx_inc;
      w_cnt_nxt       = '0;
      w_stage_rst_nxt = c_ALL_RST << w_idx_inc;
      if (r_idx == c_IDX_LAST) begin
        w_state_nxt = ST_RUN;
        w_ready_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_RELEASE;
      end
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_PLLRST;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pll_rst   <= 1'b1;
      r_stage_rst <= c_ALL_RST;
      r_ready     <= 1'b0;
      r_relock    <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_stage_rst <= w_stage_rst_nxt;
      r_ready     <= w_ready_nxt;
      r_relock    <= w_relock_nxt;
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_stage_rst    = r_stage_rst;
  assign o_ready        = r_ready;
  assign o_relock_count = r_relock;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// tb_pll_reset_sequencer: directed timing points plus randomized lock/force traffic,
// checked every cycle against a time-based reference model of the sequencer.
module tb_pll_reset_sequencer;

  localparam int P_PRC = 4;
  localparam int P_LSC = 8;
  localparam int P_RTO = 64;
  localparam int P_NS  = 3;
  localparam int P_GAP = 4;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_ACTIVE = 3;
  localparam int PH_HELD   = 4;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic            pll_locked = 1'b0;
  logic            force_rst  = 1'b0;
  logic            pll_rst;
  logic [P_NS-1:0] stage_rst;
  logic            ready;
  logic [7:0]      relock;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYC    (P_PRC),
    .LOCK_STABLE_CYC(P_LSC),
    .RELOCK_TIMEOUT (P_RTO),
    .NUM_STAGES     (P_NS),
    .STAGE_GAP      (P_GAP)
  ) dut (
    .i_clk_sys     (clk),
    .i_reset_n     (rst_n),
    .i_pll_locked  (pll_locked),
    .i_force_reset (force_rst),
    .o_pll_rst     (pll_rst),
    .o_stage_rst   (stage_rst),
    .o_ready       (ready),
    .o_relock_count(relock)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: phase plus time spent in it; RELEASE and RUN are one
  // "active" phase whose outputs follow from elapsed cycles alone.
  int m_phase  = PH_PULSE;
  int m_t      = 0;
  int m_relock = 0;
  bit m_dly[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic m_ready_f();
    return (m_phase == PH_ACTIVE) && (m_t >= (P_NS - 1) * P_GAP);
  endfunction

  function automatic logic [P_NS-1:0] m_stage_f();
    logic [P_NS-1:0] s;
    int rel;
    s = '1;
    if (m_phase == PH_ACTIVE) begin
      rel = 1 + m_t / P_GAP;
      for (int i = 0; i < P_NS; i++) if (i < rel) s[i] = 1'b0;
    end
    return s;
  endfunction

  task automatic go(input int ph);
    m_phase = ph;
    m_t     = 0;
  endtask

  task automatic model_step();
    bit lk;
    bit f;
    if (!rst_n) begin
      go(PH_PULSE);
      m_relock = 0;
      m_dly    = {};
      m_dly.push_back(1'b0);
      m_dly.push_back(1'b0);
      cyc = 0;
      return;
    end
    cyc++;
    lk = m_dly.pop_front();
    m_dly.push_back(pll_locked);
    f = force_rst;
    case (m_phase)
      PH_PULSE:  if (m_t + 1 == P_PRC) go(PH_WAIT); else m_t++;
      PH_WAIT:   if (lk) go(PH_STABLE); else if (m_t + 1 == P_RTO) go(PH_PULSE); else m_t++;
      PH_STABLE: if (!lk) go(PH_WAIT); else if (m_t + 1 == P_LSC) go(PH_ACTIVE); else m_t++;
      PH_ACTIVE: begin
        if (!lk) begin
          if (m_ready_f() && m_relock < 255) m_relock++;
          go(PH_WAIT);
        end else if (f) go(PH_HELD);
        else m_t++;
      end
      PH_HELD:   if (!lk) go(PH_WAIT); else if (!f) go(PH_ACTIVE);
      default:   go(PH_PULSE);
    endcase
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("pll_rst", pll_rst, m_phase == PH_PULSE);
      check("stage_rst", stage_rst, m_stage_f());
      check("ready", ready, m_ready_f());
      check("relock_count", relock, m_relock);
      check("ready_exclusive", ready && (pll_rst || (|stage_rst)), 1'b0);
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("wait_ready_timeout", ready, 1'b1);
  endtask

  task automatic wait_stage(input logic [P_NS-1:0] v, input int budget);
    int k = 0;
    while (stage_rst !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (stage_rst !== v) check("wait_stage_timeout", stage_rst, v);
  endtask

  initial begin : stim
    int drop_cnt = 0;
    int f_cnt    = 0;

    repeat (3) @(negedge clk);
    check("reset_pll_rst", pll_rst, 1'b1);
    check("reset_stage_rst", stage_rst, 3'b111);
    check("reset_ready", ready, 1'b0);
    check("reset_relock", relock, 8'd0);
    rst_n = 1'b1;

    // Power-up: lock appears in cycle 6.
    at_cyc(1);  check("s1_pll_rst_c1", pll_rst, 1'b1);
    at_cyc(3);  check("s1_pll_rst_c3", pll_rst, 1'b1);
    at_cyc(4);  check("s1_pll_rst_c4", pll_rst, 1'b0);
    at_cyc(6);  pll_locked = 1'b1;
    at_cyc(16); check("s1_stage_c16", stage_rst, 3'b111);
    at_cyc(17); check("s1_stage_c17", stage_rst, 3'b110);
    at_cyc(20); check("s1_stage_c20", stage_rst, 3'b110);
    at_cyc(21); check("s1_stage_c21", stage_rst, 3'b100);
    at_cyc(24); check("s1_stage_c24", stage_rst, 3'b100);
                check("s1_ready_c24", ready, 1'b0);
    at_cyc(25); check("s1_stage_c25", stage_rst, 3'b000);
                check("s1_ready_c25", ready, 1'b1);

    // One-cycle lock drop in RUN.
    at_cyc(40); pll_locked = 1'b0;
    at_cyc(41); pll_locked = 1'b1;
    at_cyc(42); check("s3_stage_c42", stage_rst, 3'b000);
    at_cyc(43); check("s3_stage_c43", stage_rst, 3'b111);
                check("s3_ready_c43", ready, 1'b0);
                check("s3_relock_c43", relock, 8'd1);
    at_cyc(51); check("s3_stage_c51", stage_rst, 3'b111);
    at_cyc(52); check("s3_stage_c52", stage_rst, 3'b110);
    at_cyc(60); check("s3_ready_c60", ready, 1'b1);

    // Lock lost for good: periodic PLL reset pulses.
    at_cyc(70);  pll_locked = 1'b0;
    at_cyc(80);  check("s2_relock_c80", relock, 8'd2);
                 check("s2_stage_c80", stage_rst, 3'b111);
    at_cyc(136); check("s2_pll_c136", pll_rst, 1'b0);
    at_cyc(137); check("s2_pll_c137", pll_rst, 1'b1);
    at_cyc(140); check("s2_pll_c140", pll_rst, 1'b1);
    at_cyc(141); check("s2_pll_c141", pll_rst, 1'b0);
    at_cyc(204); check("s2_pll_c204", pll_rst, 1'b0);
    at_cyc(205); check("s2_pll_c205", pll_rst, 1'b1);

    // Lock glitch while the stable count is 5.
    at_cyc(210); pll_locked = 1'b1;
    at_cyc(216); pll_locked = 1'b0;
    at_cyc(217); pll_locked = 1'b1;
    at_cyc(221); check("s4_stage_c221", stage_rst, 3'b111);
    at_cyc(227); check("s4_stage_c227", stage_rst, 3'b111);
    at_cyc(228); check("s4_stage_c228", stage_rst, 3'b110);
    at_cyc(236); check("s4_ready_c236", ready, 1'b1);

    // Force reset for 10 cycles in RUN.
    at_cyc(245); check("s5_stage_c245", stage_rst, 3'b000);
                 force_rst = 1'b1;
    at_cyc(246); check("s5_stage_c246", stage_rst, 3'b111);
                 check("s5_ready_c246", ready, 1'b0);
    at_cyc(255); check("s5_stage_c255", stage_rst, 3'b111);
                 force_rst = 1'b0;
    at_cyc(256); check("s5_stage_c256", stage_rst, 3'b110);
                 check("s5_relock_c256", relock, 8'd2);
    at_cyc(264); check("s5_ready_c264", ready, 1'b1);

    // Randomized lock drops (short and timeout-length), force pulses, rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        pll_locked = 1'b0;
        drop_cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 150))
                                               : int'($urandom_range(1, 6));
      end
      if (f_cnt > 0) begin
        f_cnt--;
        if (f_cnt == 0) force_rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        force_rst = 1'b1;
        f_cnt = int'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    pll_locked = 1'b1;
    force_rst  = 1'b0;

    // Saturation of the relock counter.
    for (int i = 0; i < 300; i++) begin
      wait_ready(200);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (4) @(negedge clk);
    end
    wait_ready(200);
    check("s6_relock_saturated", relock, 8'd255);

    // Asynchronous reset in the middle of a release.
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_stage(3'b110, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s6_async_pll_rst", pll_rst, 1'b1);
    check("s6_async_stage", stage_rst, 3'b111);
    check("s6_async_ready", ready, 1'b0);
    check("s6_async_relock", relock, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at_cyc(1); check("s6_repulse_c1", pll_rst, 1'b1);
    at_cyc(3); check("s6_repulse_c3", pll_rst, 1'b1);
    at_cyc(4); check("s6_repulse_c4", pll_rst, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
